cmd_slice_sequencer: RTL

Downstream consumer of the per-slot command array produced by the A/B command-select stage. Captures a full unpacked array of `DEPTH` small commands in one handshake, then issues the non-NOP entries one at a time, lowest index first, over a valid/ready output port. Completion is signalled with a one-cycle pulse, and the number of issued commands is reported for debug.

---
 rtl/cmd_slice_sequencer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/cmd_slice_sequencer.sv
// Captures a DEPTH-entry command array in one load handshake, then issues the
// non-NOP entries lowest index first over a valid/ready port, pulsing done at the end.
module cmd_slice_sequencer #(
    parameter int DEPTH = 9,
    parameter int CMD_W = 2,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [CMD_W-1:0] load_cmds [DEPTH-1:0],
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CMD_W-1:0] out_cmd,
    output logic [IDX_W-1:0] out_index,
    output logic             done,
    output logic [CNT_W-1:0] issued_count,
    output logic             state_dbg
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // Handshakes: a transfer happens on a rising edge where both valid and ready
    // are high. Valid never depends on ready and, once raised, stays high with
    // stable payload until the transfer (or flush/reset) completes.

    state_t             state_q, state_d;
    logic [CMD_W-1:0]   cmd_q [DEPTH-1:0];
    logic [DEPTH-1:0]   pend_q, pend_d;
    logic [DEPTH-1:0]   load_pend;
    logic [DEPTH-1:0]   rem;
    logic [IDX_W-1:0]   sel;
    logic [CNT_W-1:0]   count_d;
    logic               done_d;
    logic               load_en;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            load_pend[i] = (load_cmds[i] != '0);
        end
    end

    // Priority encoder: lowest pending slot wins.
    always_comb begin
        sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (pend_q[i]) sel = IDX_W'(i);
        end
    end

    always_comb begin
        rem      = pend_q;
        rem[sel] = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        count_d = issued_count;
        done_d  = 1'b0;
        load_en = 1'b0;
        if (flush) begin
            state_d = IDLE;
            pend_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        load_en = 1'b1;
                        pend_d  = load_pend;
                        count_d = '0;
                        if (|load_pend) state_d = ISSUE;
                        else            done_d  = 1'b1;
                    end
                end
                ISSUE: begin
                    if (out_ready) begin
                        pend_d  = rem;
                        count_d = issued_count + CNT_W'(1);
                        if (rem == '0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            done         <= 1'b0;
            issued_count <= '0;
            for (int i = 0; i < DEPTH; i++) cmd_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            done         <= done_d;
            issued_count <= count_d;
            if (load_en) begin
                for (int i = 0; i < DEPTH; i++) cmd_q[i] <= load_cmds[i];
            end
        end
    end

    // Outputs come from registered state only.
    assign load_ready = (state_q == IDLE);
    assign out_valid  = (state_q == ISSUE);
    assign out_cmd    = out_valid ? cmd_q[sel] : '0;
    assign out_index  = out_valid ? sel : '0;
    assign state_dbg  = state_q;

endmodule
